plic_claim_sequencer: RTL and testbench
=======================================

// Module: plic_claim_sequencer
// PURPOSE
//  Per-target claim/complete sequencer for the PLIC, between plic_regs (cc read/write strobes) and rv_plic_gateway.
//  Replaces the single shared defer counter with one FSM per target: optional fence-gated claim, per-target timeout,
//  per-target post-claim interrupt holdoff. Converts per-target claim/complete IDs into per-source one-hot pulses.
// PARAMETERS
//  N_SOURCE  30                        number of interrupt sources (IDs 1..N_SOURCE; 0 = none)
//  N_TARGET  2                         number of interrupt targets (harts/contexts)
//  SRCW      $clog2(N_SOURCE+1)        source ID width
//  HOLDOFF   63                        cycles eip_o is masked after a claim is issued; 0 = no holdoff
//  TIMEOUT   63                        cycles a fence-gated claim waits for fence_i before being dropped; >=1
// PORTS
//  clk_i          in   1                  clock
//  rst_i          in   1                  synchronous reset, active high
//  fence_i        in   1                  valid fence.i retired (single-cycle pulse)
//  mode_i         in   N_TARGET           per target: 0 = claim immediately, 1 = claim gated by fence_i
//  claim_re_i     in   N_TARGET           cc register read strobe per target
//  claim_id_i     in   N_TARGET x SRCW    ID presented by rv_plic_target at the read
//  complete_we_i  in   N_TARGET           cc register write strobe per target
//  complete_id_i  in   N_TARGET x SRCW    ID written to cc
//  irq_i          in   N_TARGET           raw notification from rv_plic_target
//  claim_o        out  N_SOURCE           one-hot-per-target claim pulses to gateway (ORed across targets)
//  complete_o     out  N_SOURCE           complete pulses to gateway (ORed across targets)
//  eip_o          out  N_TARGET           gated external interrupt pending to targets
//  busy_o         out  N_TARGET           target FSM not IDLE
//  timeout_o      out  N_TARGET           one-cycle pulse: pending claim dropped for lack of fence
// BEHAVIOUR
//  - Reset: all FSMs IDLE, counters 0, latched IDs 0; claim_o, complete_o, eip_o, busy_o, timeout_o all 0 at next edge.
//  - Valid ID: 1..N_SOURCE. Strobes with ID 0 or >N_SOURCE are ignored (no state change, no pulse).
//  - All outputs registered; claim_o/complete_o/timeout_o are single-cycle pulses, 1 cycle after the causing event.
//  - Per-target FSM {IDLE, PEND, HOLD}; counter cnt is CNT_W = $clog2(max(HOLDOFF,TIMEOUT)+1) bits, saturating-free.
//    IDLE: valid claim_re -> latch ID; mode 0: pulse claim_o[ID-1], go HOLD (IDLE if HOLDOFF=0); mode 1: cnt=0, PEND.
//    PEND: fence_i -> pulse claim_o[latched-1], cnt=0, HOLD (IDLE if HOLDOFF=0).
//          else cnt==TIMEOUT-1 -> pulse timeout_o, no claim, IDLE. else cnt++.
//          valid claim_re without fence -> replace latched ID, cnt=0, stay PEND (old ID unclaimed; gateway re-raises).
//          fence_i and valid claim_re same cycle -> claim old ID, latch new ID, cnt=0, stay PEND.
//    HOLD: cnt==HOLDOFF-1 -> IDLE, else cnt++. Valid claim_re handled exactly as in IDLE (restarts sequence).
//  - fence_i in IDLE, or in the same cycle as the claim_re that enters PEND, is not remembered.
//  - mode_i sampled only at claim acceptance; changes in PEND/HOLD do not affect the running sequence.
//  - eip_o[t] <= irq_i[t] & (next state of t == IDLE). Masked during PEND and HOLD; reset value 0.
//  - complete_o[ID-1] pulses for every valid complete_we, independent of FSM state; multiple targets OR together.
//  - Two targets claiming same source same cycle: single claim_o bit high (OR); both FSMs advance independently.
//  - busy_o[t] = registered (state != IDLE).
//  - Reset asserted mid-sequence: pending claims discarded without claim pulse, no timeout pulse.
// STRUCTURE
//  - plic_pkg: claim_state_e {IDLE, PEND, HOLD}; function id_valid(id, N_SOURCE); CNT_W helper.
//  - Sub-module plic_claim_fsm (one per target, generate loop): FSM, counter, latched ID, per-target claim/timeout.
//  - Top: ID->one-hot decode and OR-reduction for claim_o/complete_o, output registers.
// TESTING
//  1 mode0, claim_re t0 ID=5, HOLDOFF=63 -> claim_o[4] pulse 1 cycle later; eip_o[0] low 63 cycles, then follows irq_i.
//  2 mode1, claim_re ID=3, fence_i 10 cycles later -> claim_o[2] pulse next cycle, state HOLD, no timeout_o.
//  3 mode1, claim_re ID=7, no fence, TIMEOUT=63 -> timeout_o[0] pulse after 63 cycles, claim_o stays 0, busy_o falls.
//  4 mode1 PEND ID=2, fence_i + claim_re ID=9 same cycle -> claim_o[1] pulse, stays PEND with ID 9.
//  5 both targets complete_we ID=4 same cycle, plus ID=0 and ID=31 -> only complete_o[3] pulses, once.
//  6 rst_i mid-PEND and mid-HOLD -> all outputs 0 next edge; later fence_i produces no claim_o.

Source files
------------

// File: rtl/plic_claim_sequencer_pkg.sv
// Shared types and helpers for the PLIC per-target claim/complete sequencer.
package plic_claim_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HOLD = 2'd2
  } claim_state_e;

  // Counter width able to hold max(holdoff, timeout); never narrower than 1 bit.
  function automatic int cnt_w(input int holdoff, input int timeout);
    int m;
    m = (holdoff > timeout) ? holdoff : timeout;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  function automatic logic id_valid(input int unsigned id, input int unsigned n_source);
    return (id != 0) && (id <= n_source);
  endfunction

endpackage

// File: rtl/plic_claim_sequencer_if.sv
// cc strobe / gateway pulse bundle between plic_regs, the sequencer and rv_plic_gateway.
interface plic_claim_sequencer_if #(
  parameter int N_SOURCE = 30,
  parameter int N_TARGET = 2,
  parameter int SRCW     = $clog2(N_SOURCE + 1)
);
  logic                               fence_i;
  logic [N_TARGET-1:0]                mode_i;
  logic [N_TARGET-1:0]                claim_re_i;
  logic [N_TARGET-1:0][SRCW-1:0]      claim_id_i;
  logic [N_TARGET-1:0]                complete_we_i;
  logic [N_TARGET-1:0][SRCW-1:0]      complete_id_i;
  logic [N_TARGET-1:0]                irq_i;
  logic [N_SOURCE-1:0]                claim_o;
  logic [N_SOURCE-1:0]                complete_o;
  logic [N_TARGET-1:0]                eip_o;
  logic [N_TARGET-1:0]                busy_o;
  logic [N_TARGET-1:0]                timeout_o;

  modport master (
    output fence_i, mode_i, claim_re_i, claim_id_i, complete_we_i, complete_id_i, irq_i,
    input  claim_o, complete_o, eip_o, busy_o, timeout_o
  );

  modport slave (
    input  fence_i, mode_i, claim_re_i, claim_id_i, complete_we_i, complete_id_i, irq_i,
    output claim_o, complete_o, eip_o, busy_o, timeout_o
  );
endinterface

// File: rtl/plic_claim_sequencer_fsm.sv
// One target's claim sequence: IDLE -> (PEND on fence) -> HOLD holdoff -> IDLE.
// Emits combinational fire strobes; the top registers and decodes them.
module plic_claim_sequencer_fsm
  import plic_claim_sequencer_pkg::*;
#(
  parameter int N_SOURCE = 30,
  parameter int SRCW     = $clog2(N_SOURCE + 1),
  parameter int HOLDOFF  = 63,
  parameter int TIMEOUT  = 63
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            fence_i,
  input  logic            mode_i,
  input  logic            claim_re_i,
  input  logic [SRCW-1:0] claim_id_i,
  output logic            claim_fire_o,
  output logic [SRCW-1:0] claim_fire_id_o,
  output logic            timeout_fire_o,
  output logic            next_idle_o
);
  localparam int CNT_W = cnt_w(HOLDOFF, TIMEOUT);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam claim_state_e AFTER_CLAIM   = (HOLDOFF == 0) ? IDLE : HOLD;

  claim_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SRCW-1:0]  id_q, id_d;
  logic             acc;

  assign acc = claim_re_i && id_valid(32'(claim_id_i), N_SOURCE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    unique case (state_q)
      PEND: begin
        // A new claim in PEND always re-arms the wait, even alongside a fence.
        if (acc) begin
          id_d  = claim_id_i;
          cnt_d = '0;
        end else if (fence_i) begin
          cnt_d   = '0;
          state_d = AFTER_CLAIM;
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE, HOLD: begin
        if (acc) begin
          id_d    = claim_id_i;
          cnt_d   = '0;
          state_d = mode_i ? PEND : AFTER_CLAIM;
        end else if (state_q == HOLD) begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    claim_fire_o    = 1'b0;
    claim_fire_id_o = id_q;
    timeout_fire_o  = 1'b0;
    unique case (state_q)
      PEND: begin
        if (fence_i) claim_fire_o = 1'b1;
        else if (!acc && cnt_q == TO_LAST) timeout_fire_o = 1'b1;
      end
      default: begin
        if (acc && !mode_i) begin
          claim_fire_o    = 1'b1;
          claim_fire_id_o = claim_id_i;
        end
      end
    endcase
    next_idle_o = (state_d == IDLE);
  end

endmodule

// File: rtl/plic_claim_sequencer.sv
// PLIC claim/complete sequencer: one FSM per target, ID -> one-hot decode,
// OR-reduction across targets and fully registered outputs.
module plic_claim_sequencer
  import plic_claim_sequencer_pkg::*;
#(
  parameter int N_SOURCE = 30,
  parameter int N_TARGET = 2,
  parameter int SRCW     = $clog2(N_SOURCE + 1),
  parameter int HOLDOFF  = 63,
  parameter int TIMEOUT  = 63
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  plic_claim_sequencer_if.slave bus
);
  logic [N_TARGET-1:0]           claim_fire, timeout_fire, next_idle;
  logic [N_TARGET-1:0][SRCW-1:0] fire_id;

  logic [N_SOURCE-1:0] claim_q, claim_d, complete_q, complete_d;
  logic [N_TARGET-1:0] eip_q, eip_d, busy_q, busy_d, timeout_q, timeout_d;

  for (genvar t = 0; t < N_TARGET; t++) begin : g_tgt
    plic_claim_sequencer_fsm #(
      .N_SOURCE(N_SOURCE),
      .SRCW    (SRCW),
      .HOLDOFF (HOLDOFF),
      .TIMEOUT (TIMEOUT)
    ) u_fsm (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .fence_i        (bus.fence_i),
      .mode_i         (bus.mode_i[t]),
      .claim_re_i     (bus.claim_re_i[t]),
      .claim_id_i     (bus.claim_id_i[t]),
      .claim_fire_o   (claim_fire[t]),
      .claim_fire_id_o(fire_id[t]),
      .timeout_fire_o (timeout_fire[t]),
      .next_idle_o    (next_idle[t])
    );
  end

  always_comb begin
    claim_d    = '0;
    complete_d = '0;
    // Fired claim IDs were range-checked at acceptance, so the index is safe.
    for (int t = 0; t < N_TARGET; t++) begin
      if (claim_fire[t]) claim_d[fire_id[t] - SRCW'(1)] = 1'b1;
      if (bus.complete_we_i[t] && id_valid(32'(bus.complete_id_i[t]), N_SOURCE))
        complete_d[bus.complete_id_i[t] - SRCW'(1)] = 1'b1;
    end
    eip_d     = bus.irq_i & next_idle;
    busy_d    = ~next_idle;
    timeout_d = timeout_fire;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      claim_q    <= '0;
      complete_q <= '0;
      eip_q      <= '0;
      busy_q     <= '0;
      timeout_q  <= '0;
    end else begin
      claim_q    <= claim_d;
      complete_q <= complete_d;
      eip_q      <= eip_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.claim_o    = claim_q;
  assign bus.complete_o = complete_q;
  assign bus.eip_o      = eip_q;
  assign bus.busy_o     = busy_q;
  assign bus.timeout_o  = timeout_q;

endmodule

// File: tb/tb_plic_claim_sequencer.sv
// Bench for plic_claim_sequencer: directed scenarios plus random traffic vs a
// deadline-based reference model.
module tb_plic_claim_sequencer;
  localparam int NS = 30;
  localparam int NT = 2;
  localparam int SW = $clog2(NS + 1);
  localparam int HO = 63;
  localparam int TO = 63;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  plic_claim_sequencer_if #(.N_SOURCE(NS), .N_TARGET(NT), .SRCW(SW)) bus ();

  plic_claim_sequencer #(
    .N_SOURCE(NS), .N_TARGET(NT), .SRCW(SW), .HOLDOFF(HO), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: phase 0 idle, 1 waiting for fence, 2 holdoff; lim = cycle on which phase ends.
  int ph [NT];
  int mid[NT];
  int lim[NT];
  logic [NS-1:0] e_claim, e_comp;
  logic [NT-1:0] e_eip, e_busy, e_to;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, act, exp);
    end
  endtask

  function automatic bit vid(input int id);
    return (id >= 1) && (id <= NS);
  endfunction

  task automatic clr();
    bus.fence_i       = 1'b0;
    bus.mode_i        = '0;
    bus.claim_re_i    = '0;
    bus.claim_id_i    = '0;
    bus.complete_we_i = '0;
    bus.complete_id_i = '0;
    bus.irq_i         = '0;
  endtask

  task automatic model();
    e_claim = '0;
    e_comp  = '0;
    e_to    = '0;
    if (rst) begin
      for (int t = 0; t < NT; t++) begin
        ph[t]  = 0;
        mid[t] = 0;
      end
      e_eip  = '0;
      e_busy = '0;
      return;
    end
    for (int t = 0; t < NT; t++) begin
      int nid;
      int wid;
      bit acc;
      nid = int'(bus.claim_id_i[t]);
      wid = int'(bus.complete_id_i[t]);
      acc = bus.claim_re_i[t] && vid(nid);
      if (ph[t] == 1) begin
        if (bus.fence_i) e_claim[mid[t]-1] = 1'b1;
        if (acc) begin
          mid[t] = nid;
          lim[t] = cyc + TO;
        end else if (bus.fence_i) begin
          ph[t]  = (HO > 0) ? 2 : 0;
          lim[t] = cyc + HO;
        end else if (cyc == lim[t]) begin
          e_to[t] = 1'b1;
          ph[t]   = 0;
        end
      end else if (acc) begin
        mid[t] = nid;
        if (bus.mode_i[t]) begin
          ph[t]  = 1;
          lim[t] = cyc + TO;
        end else begin
          e_claim[nid-1] = 1'b1;
          ph[t]  = (HO > 0) ? 2 : 0;
          lim[t] = cyc + HO;
        end
      end else if (ph[t] == 2 && cyc == lim[t]) begin
        ph[t] = 0;
      end
      if (bus.complete_we_i[t] && vid(wid)) e_comp[wid-1] = 1'b1;
      e_eip[t]  = bus.irq_i[t] && (ph[t] == 0);
      e_busy[t] = (ph[t] != 0);
    end
  endtask

  task automatic step();
    model();
    @(posedge clk);
    #1;
    chk("claim_o",    64'(bus.claim_o),    64'(e_claim));
    chk("complete_o", 64'(bus.complete_o), 64'(e_comp));
    chk("eip_o",      64'(bus.eip_o),      64'(e_eip));
    chk("busy_o",     64'(bus.busy_o),     64'(e_busy));
    chk("timeout_o",  64'(bus.timeout_o),  64'(e_to));
    cyc++;
  endtask

  initial begin
    logic [NS-1:0] z;
    z = '0;
    clr();
    rst = 1'b1;
    step();
    step();
    chk("rst_busy", 64'(bus.busy_o), 64'(0));
    rst = 1'b0;
    step();

    // 1: immediate claim, holdoff masks eip for HO cycles
    bus.irq_i = 2'b11;
    bus.claim_re_i[0] = 1'b1;
    bus.claim_id_i[0] = 5'd5;
    step();
    chk("s1_claim", 64'(bus.claim_o), 64'(30'h10));
    bus.claim_re_i = '0;
    repeat (HO - 1) step();
    chk("s1_eip_masked", 64'(bus.eip_o[0]), 64'(0));
    step();
    chk("s1_eip_open", 64'(bus.eip_o[0]), 64'(1));
    bus.irq_i = '0;

    // 2: fence-gated claim released by fence
    bus.mode_i[0] = 1'b1;
    bus.claim_re_i[0] = 1'b1;
    bus.claim_id_i[0] = 5'd3;
    step();
    bus.claim_re_i = '0;
    repeat (9) step();
    bus.fence_i = 1'b1;
    step();
    bus.fence_i = 1'b0;
    chk("s2_claim", 64'(bus.claim_o), 64'(30'h4));
    chk("s2_busy", 64'(bus.busy_o[0]), 64'(1));
    chk("s2_no_to", 64'(bus.timeout_o), 64'(0));
    repeat (HO) step();
    chk("s2_idle", 64'(bus.busy_o[0]), 64'(0));

    // 3: fence never comes -> timeout
    bus.claim_re_i[0] = 1'b1;
    bus.claim_id_i[0] = 5'd7;
    step();
    bus.claim_re_i = '0;
    repeat (TO - 1) step();
    chk("s3_no_to_yet", 64'(bus.timeout_o[0]), 64'(0));
    step();
    chk("s3_to", 64'(bus.timeout_o[0]), 64'(1));
    chk("s3_no_claim", 64'(bus.claim_o), 64'(z));
    chk("s3_idle", 64'(bus.busy_o[0]), 64'(0));

    // 4: fence and new claim together: old ID claimed, new ID pending
    bus.claim_re_i[0] = 1'b1;
    bus.claim_id_i[0] = 5'd2;
    step();
    bus.fence_i = 1'b1;
    bus.claim_id_i[0] = 5'd9;
    step();
    chk("s4_old", 64'(bus.claim_o), 64'(30'h2));
    chk("s4_busy", 64'(bus.busy_o[0]), 64'(1));
    bus.claim_re_i = '0;
    step();
    bus.fence_i = 1'b0;
    chk("s4_new", 64'(bus.claim_o), 64'(30'h100));
    repeat (HO) step();
    bus.mode_i = '0;

    // 5: completes ORed, invalid IDs ignored
    bus.complete_we_i = 2'b11;
    bus.complete_id_i[0] = 5'd4;
    bus.complete_id_i[1] = 5'd4;
    step();
    chk("s5_or", 64'(bus.complete_o), 64'(30'h8));
    bus.complete_id_i[0] = 5'd0;
    bus.complete_id_i[1] = 5'd31;
    step();
    chk("s5_invalid", 64'(bus.complete_o), 64'(z));
    bus.complete_we_i = '0;

    // 6: reset mid-PEND and mid-HOLD
    bus.mode_i = 2'b01;
    bus.claim_re_i = 2'b11;
    bus.claim_id_i[0] = 5'd6;
    bus.claim_id_i[1] = 5'd11;
    bus.irq_i = 2'b11;
    step();
    bus.claim_re_i = '0;
    step();
    rst = 1'b1;
    step();
    chk("s6_busy", 64'(bus.busy_o), 64'(0));
    chk("s6_eip", 64'(bus.eip_o), 64'(0));
    rst = 1'b0;
    bus.fence_i = 1'b1;
    step();
    chk("s6_no_claim", 64'(bus.claim_o), 64'(z));
    clr();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.fence_i = ($urandom_range(0, 11) == 0);
      bus.mode_i  = NT'($urandom);
      bus.irq_i   = NT'($urandom);
      for (int t = 0; t < NT; t++) begin
        bus.claim_re_i[t]    = ($urandom_range(0, 7) == 0);
        bus.claim_id_i[t]    = SW'($urandom_range(0, 31));
        bus.complete_we_i[t] = ($urandom_range(0, 5) == 0);
        bus.complete_id_i[t] = SW'($urandom_range(0, 31));
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
